dsp_mac_pipe: RTL and testbench

Parametrised, fully pipelined signed multiply-accumulate slice. It succeeds the fixed-width DSP48E1 model in the arithmetic library. It adds:
- generic operand and accumulator widths;
- an optional pre-adder;
- a valid-tracked pipeline, so bubbles never disturb the accumulator;
- selectable saturation with overflow reporting;
- a masked pattern detector.

It sits in datapaths that need MAC/FIR-tap arithmetic narrower or wider than the 25x18/48 hard-macro shape, and cascades slice-to-slice through `pcin`/`pcout`.

---
 rtl/dsp_mac_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// ============================================================================
// dsp_mac_pipe
// ----------------------------------------------------------------------------
// A fully pipelined signed multiply-accumulate slice with three register
// stages. It has an optional pre-adder (D+A), an ALU that can accumulate,
// subtract, add C or add the cascade input, optional saturation with overflow
// reporting, and a masked pattern detector on P. Each slice feeds the next
// through pcout -> pcin.
//
// Parameters
//   AW          A and D operand width (signed)
//   BW          B operand width (signed)
//   PW          accumulator / P width, must be >= AW+1+BW
//   USE_PREADD  1: multiplier input may be D+A (selected by use_d), 0: always A
//   SAT_EN      1: clamp on signed overflow, 0: two's-complement wrap
//   PATTERN     value compared against P
//   MASK        bits set to 1 are excluded from the pattern comparison
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset; takes priority over ce
//   ce        clock enable; 0 freezes every register, valid bits included
//   in_valid  qualifies the stage-1 inputs
//   a, d      signed A / D operands (AW bits)
//   b         signed B operand (BW bits)
//   c         signed addend C (PW bits)
//   pcin      cascade input from the upstream slice
//   use_d     1 selects D+A as the multiplier input
//   opmode    ALU operation; travels down the pipe with its data
//   p         result register
//   pcout     copy of p for cascading
//   p_valid   p was updated by a valid operation on this cycle
//   overflow  signed overflow on the last update (clamped or wrapped)
//   patdet    ((p ^ PATTERN) & ~MASK) == 0, registered together with p
// ============================================================================
module dsp_mac_pipe #(
    parameter int              AW         = 25,
    parameter int              BW         = 18,
    parameter int              PW         = 48,
    parameter int              USE_PREADD = 1,
    parameter int              SAT_EN     = 0,
    parameter logic [PW-1:0]   PATTERN    = '0,
    parameter logic [PW-1:0]   MASK       = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] d,
    input  logic signed [BW-1:0] b,
    input  logic signed [PW-1:0] c,
    input  logic signed [PW-1:0] pcin,
    input  logic                 use_d,
    input  logic [2:0]           opmode,
    output logic signed [PW-1:0] p,
    output logic signed [PW-1:0] pcout,
    output logic                 p_valid,
    output logic                 overflow,
    output logic                 patdet
);

    localparam int MW = AW + 1 + BW;

    generate
        if (PW < MW) begin : g_pw_too_small
            $error("dsp_mac_pipe: PW must be >= AW+1+BW");
        end
    endgenerate

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_M    = 3'b001;
    localparam logic [2:0] OP_PADD = 3'b010;
    localparam logic [2:0] OP_PSUB = 3'b011;
    localparam logic [2:0] OP_CADD = 3'b100;
    localparam logic [2:0] OP_CSUB = 3'b101;
    localparam logic [2:0] OP_HOLD = 3'b110;
    localparam logic [2:0] OP_CASC = 3'b111;

    localparam logic signed [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};

    // A PW+1-bit sum overflows PW bits when its top two bits disagree.
    function automatic logic sum_ovf(input logic signed [PW:0] s);
        return s[PW] ^ s[PW-1];
    endfunction

    function automatic logic signed [PW-1:0] sat_sum(input logic signed [PW:0] s);
        logic signed [PW-1:0] r;
        if ((SAT_EN != 0) && sum_ovf(s)) begin
            r = s[PW] ? P_MIN : P_MAX;
        end else begin
            r = s[PW-1:0];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- stage 1
    logic signed [AW-1:0] a_p0, d_p0;
    logic signed [BW-1:0] b_p0;
    logic signed [PW-1:0] c_p0, pcin_p0;
    logic                 use_d_p0;
    logic [2:0]           opmode_p0;
    logic                 vld_p0;

    logic signed [AW:0]   ad_p0;
    logic signed [MW-1:0] mult_p0;

    always_comb begin
        ad_p0 = {a_p0[AW-1], a_p0};
        if ((USE_PREADD != 0) && use_d_p0) begin
            ad_p0 = {d_p0[AW-1], d_p0} + {a_p0[AW-1], a_p0};
        end
    end

    assign mult_p0 = MW'(ad_p0) * MW'(b_p0);

    // ---------------------------------------------------------------- stage 2
    logic signed [PW-1:0] m_p1, c_p1, pcin_p1;
    logic [2:0]           opmode_p1;
    logic                 vld_p1;

    logic signed [PW:0]   m_x, c_x, pcin_x, p_x;
    logic signed [PW:0]   sum_p1;
    logic signed [PW-1:0] p_next;
    logic                 ovf_next;
    logic                 patdet_next;

    logic signed [PW-1:0] p_p2;

    assign m_x    = {m_p1[PW-1], m_p1};
    assign c_x    = {c_p1[PW-1], c_p1};
    assign pcin_x = {pcin_p1[PW-1], pcin_p1};
    assign p_x    = {p_p2[PW-1], p_p2};

    always_comb begin
        sum_p1 = '0;
        case (opmode_p1)
            OP_ZERO: sum_p1 = '0;
            OP_M:    sum_p1 = m_x;
            OP_PADD: sum_p1 = p_x + m_x;
            OP_PSUB: sum_p1 = p_x - m_x;
            OP_CADD: sum_p1 = c_x + m_x;
            OP_CSUB: sum_p1 = c_x - m_x;
            OP_HOLD: sum_p1 = p_x;
            OP_CASC: sum_p1 = pcin_x + m_x;
            default: sum_p1 = '0;
        endcase
    end

    assign p_next      = sat_sum(sum_p1);
    assign ovf_next    = sum_ovf(sum_p1);
    assign patdet_next = ((p_next ^ PATTERN) & ~MASK) == '0;

    // ---------------------------------------------------------------- stage 3
    logic ovf_p2, patdet_p2, vld_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_p0      <= '0;
            d_p0      <= '0;
            b_p0      <= '0;
            c_p0      <= '0;
            pcin_p0   <= '0;
            use_d_p0  <= 1'b0;
            opmode_p0 <= '0;
            vld_p0    <= 1'b0;
            m_p1      <= '0;
            c_p1      <= '0;
            pcin_p1   <= '0;
            opmode_p1 <= '0;
            vld_p1    <= 1'b0;
            p_p2      <= '0;
            ovf_p2    <= 1'b0;
            patdet_p2 <= 1'b0;
            vld_p2    <= 1'b0;
        end else if (ce) begin
            a_p0      <= a;
            d_p0      <= d;
            b_p0      <= b;
            c_p0      <= c;
            pcin_p0   <= pcin;
            use_d_p0  <= use_d;
            opmode_p0 <= opmode;
            vld_p0    <= in_valid;

            m_p1      <= PW'(mult_p0);
            c_p1      <= c_p0;
            pcin_p1   <= pcin_p0;
            opmode_p1 <= opmode_p0;
            vld_p1    <= vld_p0;

            vld_p2    <= vld_p1;
            // Bubbles leave P, overflow and patdet untouched so the
            // accumulator only sees real operations.
            if (vld_p1) begin
                p_p2      <= p_next;
                ovf_p2    <= ovf_next;
                patdet_p2 <= patdet_next;
            end
        end
    end

    assign p        = p_p2;
    assign pcout    = p_p2;
    assign p_valid  = vld_p2;
    assign overflow = ovf_p2;
    assign patdet   = patdet_p2;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
module tb_dsp_mac_pipe;

    logic clk = 1'b0;
    logic rst, ce, in_valid, use_d;
    logic [2:0] opmode;
    logic signed [24:0] a, d;
    logic signed [17:0] b;
    logic signed [47:0] c, pcin;
    logic signed [7:0]  sa, sd, sb;
    logic signed [17:0] sc, spcin;

    logic signed [47:0] p_def, pc_def, p_nop, pc_nop;
    logic pv_def, ov_def, pd_def, pv_nop, ov_nop, pd_nop;
    logic signed [17:0] p_sat, pc_sat, p_wrp, pc_wrp;
    logic pv_sat, ov_sat, pd_sat, pv_wrp, ov_wrp, pd_wrp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsp_mac_pipe u_def (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .d(d), .b(b),
        .c(c), .pcin(pcin), .use_d(use_d), .opmode(opmode), .p(p_def),
        .pcout(pc_def), .p_valid(pv_def), .overflow(ov_def), .patdet(pd_def));

    dsp_mac_pipe #(.USE_PREADD(0)) u_nop (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .d(d), .b(b),
        .c(c), .pcin(pcin), .use_d(use_d), .opmode(opmode), .p(p_nop),
        .pcout(pc_nop), .p_valid(pv_nop), .overflow(ov_nop), .patdet(pd_nop));

    dsp_mac_pipe #(.AW(8), .BW(8), .PW(18), .SAT_EN(1)) u_sat (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(sa), .d(sd), .b(sb),
        .c(sc), .pcin(spcin), .use_d(use_d), .opmode(opmode), .p(p_sat),
        .pcout(pc_sat), .p_valid(pv_sat), .overflow(ov_sat), .patdet(pd_sat));

    dsp_mac_pipe #(.AW(8), .BW(8), .PW(18), .SAT_EN(0)) u_wrp (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(sa), .d(sd), .b(sb),
        .c(sc), .pcin(spcin), .use_d(use_d), .opmode(opmode), .p(p_wrp),
        .pcout(pc_wrp), .p_valid(pv_wrp), .overflow(ov_wrp), .patdet(pd_wrp));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [2:0] op, input int av, input int bv, input int cv);
        in_valid = v;
        opmode   = op;
        a        = 25'(av);
        b        = 18'(bv);
        c        = 48'(cv);
    endtask

    task automatic sput(input int av, input int bv, input int cv);
        sa = 8'(av);
        sb = 8'(bv);
        sc = 18'(cv);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; use_d = 1'b0;
        d = '0; pcin = '0; sd = '0; spcin = '0;
        put(1'b0, 3'b000, 0, 0, 0);
        sput(0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_p", 64'(p_def), 0);
        chk("rst_pcout", 64'(pc_def), 0);
        chk("rst_pvalid", 64'(pv_def), 0);
        chk("rst_ovf", 64'(ov_def), 0);
        chk("rst_patdet", 64'(pd_def), 0);

        // basic multiply: 3 * -4, three-clock latency
        put(1'b1, 3'b001, 3, -4, 0);
        tick();
        put(1'b0, 3'b001, 0, 0, 0);
        tick();
        chk("lat_early_pvalid", 64'(pv_def), 0);
        tick();
        chk("mul_pvalid", 64'(pv_def), 1);
        chk("mul_p", 64'(p_def), -12);
        chk("mul_pcout", 64'(pc_def), -12);
        chk("mul_ovf", 64'(ov_def), 0);
        chk("mul_patdet", 64'(pd_def), 0);
        tick();
        chk("mul_pvalid_drop", 64'(pv_def), 0);
        chk("mul_p_hold", 64'(p_def), -12);

        // pre-adder: (10 + 5) * 2, and without pre-adder 5 * 2
        put(1'b1, 3'b001, 5, 2, 0);
        use_d = 1'b1;
        d = 25'(10);
        tick();
        put(1'b0, 3'b001, 0, 0, 0);
        use_d = 1'b0;
        tick();
        tick();
        chk("preadd_p", 64'(p_def), 30);
        chk("nopreadd_p", 64'(p_nop), 10);

        // accumulate with a bubble: 6, hold, 26, 25
        put(1'b1, 3'b001, 2, 3, 0);
        tick();
        put(1'b0, 3'b001, 99, 99, 0);
        tick();
        put(1'b1, 3'b010, 4, 5, 0);
        tick();
        chk("acc1_p", 64'(p_def), 6);
        chk("acc1_pvalid", 64'(pv_def), 1);
        put(1'b1, 3'b011, 1, 1, 0);
        tick();
        chk("bubble_p", 64'(p_def), 6);
        chk("bubble_pvalid", 64'(pv_def), 0);
        put(1'b0, 3'b000, 0, 0, 0);
        tick();
        chk("acc2_p", 64'(p_def), 26);
        chk("acc2_pvalid", 64'(pv_def), 1);
        tick();
        chk("acc3_p", 64'(p_def), 25);
        chk("acc3_pvalid", 64'(pv_def), 1);

        // C-M, pcin+M, hold, zero
        put(1'b1, 3'b101, 3, 4, 100);
        tick();
        put(1'b1, 3'b111, 10, 10, 0);
        pcin = 48'(-1000);
        tick();
        put(1'b1, 3'b110, 0, 0, 0);
        tick();
        chk("csub_p", 64'(p_def), 88);
        put(1'b1, 3'b000, 7, 7, 0);
        tick();
        chk("casc_p", 64'(p_def), -900);
        put(1'b0, 3'b000, 0, 0, 0);
        tick();
        chk("hold_p", 64'(p_def), -900);
        chk("hold_pvalid", 64'(pv_def), 1);
        tick();
        chk("zero_p", 64'(p_def), 0);
        chk("zero_patdet", 64'(pd_def), 1);

        // saturation vs wrap on the 8x8/18 slices
        put(1'b1, 3'b100, 0, 0, 7);
        sput(127, 127, 131000);
        tick();
        put(1'b1, 3'b101, 0, 0, 7);
        sput(127, 127, -131000);
        tick();
        put(1'b1, 3'b001, 0, 0, 7);
        sput(1, 1, 0);
        tick();
        chk("sat_pos_p", 64'(p_sat), 131071);
        chk("sat_pos_ovf", 64'(ov_sat), 1);
        chk("wrap_pos_p", 64'(p_wrp), -115015);
        chk("wrap_pos_ovf", 64'(ov_wrp), 1);
        chk("cadd_def_p", 64'(p_def), 7);
        put(1'b0, 3'b000, 0, 0, 0);
        tick();
        chk("sat_neg_p", 64'(p_sat), -131072);
        chk("sat_neg_ovf", 64'(ov_sat), 1);
        chk("wrap_neg_p", 64'(p_wrp), 115015);
        tick();
        chk("sat_clear_p", 64'(p_sat), 1);
        chk("sat_clear_ovf", 64'(ov_sat), 0);
        chk("wrap_clear_ovf", 64'(ov_wrp), 0);

        // pattern detect and a 4-cycle stall
        put(1'b1, 3'b001, 2, 2, 0);
        tick();
        put(1'b1, 3'b001, 5, 0, 0);
        tick();
        put(1'b0, 3'b000, 0, 0, 0);
        tick();
        chk("prestall_p", 64'(p_def), 4);
        chk("prestall_patdet", 64'(pd_def), 0);
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_p", 64'(p_def), 4);
            chk("stall_pvalid", 64'(pv_def), 1);
        end
        ce = 1'b1;
        tick();
        chk("poststall_p", 64'(p_def), 0);
        chk("poststall_pvalid", 64'(pv_def), 1);
        chk("poststall_patdet", 64'(pd_def), 1);
        tick();
        chk("poststall_nodup", 64'(pv_def), 0);

        // reset mid-pipeline, asserted together with ce=0
        put(1'b1, 3'b001, 1, 1, 0);
        tick();
        tick();
        tick();
        chk("prerst_p", 64'(p_def), 1);
        rst = 1'b1;
        ce  = 1'b0;
        tick();
        chk("midrst_p", 64'(p_def), 0);
        chk("midrst_pvalid", 64'(pv_def), 0);
        rst = 1'b0;
        ce  = 1'b1;
        put(1'b0, 3'b000, 0, 0, 0);
        tick();
        chk("postrst_stale1", 64'(pv_def), 0);
        tick();
        chk("postrst_stale2", 64'(pv_def), 0);
        chk("postrst_p", 64'(p_def), 0);

        // accumulate right after reset starts from zero
        put(1'b1, 3'b010, 3, 3, 0);
        tick();
        put(1'b0, 3'b000, 0, 0, 0);
        tick();
        tick();
        chk("acc_after_rst_p", 64'(p_def), 9);
        chk("acc_after_rst_pvalid", 64'(pv_def), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
